// File: rtl/spio_hss_multiplexer_frame_rx_pkg.sv
// Shared constants and types for the HSS multiplexer frame receiver and its
// CRC-16 helper: control character, CRC parameters, header field layout and
// the receive FSM state encoding.
package spio_hss_multiplexer_frame_rx_pkg;

    // K character carried in the top byte of a frame header
    localparam logic [7:0]  KCH_DATA    = 8'h5C;

    // CRC-16-CCITT parameters
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    // Header layout: [31:24] K char, [23:16] sequence, [3:0] length
    localparam int          HDR_KCH_LSB = 24;
    localparam int          HDR_SEQ_LSB = 16;
    localparam int          HDR_LEN_LSB = 0;
    localparam logic [3:0]  HDR_CHARISK = 4'b1000;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PAYLOAD,
        RX_CHECK
    } rx_state_t;

endpackage

// File: rtl/spio_hss_multiplexer_frame_rx_if.sv
// Ready/valid payload port of the frame receiver. The receiver is the master
// (drives data/last/valid), the downstream consumer is the slave (drives ready).
interface spio_hss_multiplexer_frame_rx_if;

    logic [31:0] frm_data;
    logic        frm_last;
    logic        frm_vld;
    logic        frm_rdy;

    modport master (
        output frm_data,
        output frm_last,
        output frm_vld,
        input  frm_rdy
    );

    modport slave (
        input  frm_data,
        input  frm_last,
        input  frm_vld,
        output frm_rdy
    );

endinterface

// File: rtl/spio_hss_multiplexer_crc16.sv
// Combinational CRC-16 update over one 32-bit word, most significant bit
// first. Shared between the frame receiver and the frame transmitter.
module spio_hss_multiplexer_crc16
    import spio_hss_multiplexer_frame_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [31:0] data,
    output logic [15:0] crc_out
);

    // Shift the 32 data bits through the CRC register one at a time
    always_comb begin
        logic [15:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// Frame receiver behind the HSS rx control stage. Parses header/payload/CRC
// frames, checks CRC and sequence number, buffers one frame and releases it
// on a ready/valid port once accepted, and reports ACK/NAK to the tx side.
module spio_hss_multiplexer_frame_rx
    import spio_hss_multiplexer_frame_rx_pkg::*;
#(
    parameter int NUM_WORDS      = 8,
    parameter int NUM_WORDS_BITS = 3
)
(
    input  logic                                   CLK_IN,
    input  logic                                   RESET_IN,
    input  logic                                   HANDSHAKE_COMPLETE_IN,
    input  logic [31:0]                            RXDATA_IN,
    input  logic [3:0]                             RXCHARISK_IN,
    input  logic                                   RXVLD_IN,
    spio_hss_multiplexer_frame_rx_if.master        frm_if,
    output logic                                   ACK_VLD_OUT,
    output logic                                   NAK_VLD_OUT,
    output logic [7:0]                             ACK_SEQ_OUT,
    output logic                                   CRC_ERR_OUT,
    output logic                                   FRAMING_ERR_OUT
);

    localparam logic [3:0] MAX_LEN = 4'(NUM_WORDS);

    rx_state_t                 state;
    logic [7:0]                exp_seq;
    logic [7:0]                rx_seq;
    logic [3:0]                rx_len;
    logic [3:0]                cnt;
    logic [15:0]               crc_reg;
    logic                      committed;
    logic [NUM_WORDS_BITS-1:0] rd_ptr;

    logic                      ack_vld;
    logic                      nak_vld;
    logic [7:0]                ack_seq;
    logic                      crc_err;
    logic                      framing_err;

    logic [32:0]               frame_buf [NUM_WORDS];

    logic                      is_hdr;
    logic [3:0]                hdr_len;
    logic                      len_ok;
    logic                      xfer;
    logic                      final_xfer;
    logic                      buf_busy;
    logic                      buf_wr;
    logic [15:0]               crc_seed;
    logic [15:0]               crc_next;

    assign is_hdr     = RXVLD_IN && (RXCHARISK_IN == HDR_CHARISK) &&
                        (RXDATA_IN[HDR_KCH_LSB +: 8] == KCH_DATA);
    assign hdr_len    = RXDATA_IN[HDR_LEN_LSB +: 4];
    assign len_ok     = (hdr_len != 4'd0) && (hdr_len <= MAX_LEN);
    assign xfer       = committed && frm_if.frm_rdy;
    assign final_xfer = xfer && frame_buf[rd_ptr][32];
    assign buf_busy   = committed && !final_xfer;
    assign buf_wr     = HANDSHAKE_COMPLETE_IN && RXVLD_IN &&
                        (state == RX_PAYLOAD) && (RXCHARISK_IN == 4'b0000);

    // A header always restarts the CRC, even when it aborts a frame in flight
    assign crc_seed   = is_hdr ? CRC16_INIT : crc_reg;

    spio_hss_multiplexer_crc16 crc_u (
        .crc_in  (crc_seed),
        .data    (RXDATA_IN),
        .crc_out (crc_next)
    );

    // Payload storage; only written while no committed frame is draining
    always_ff @(posedge CLK_IN) begin
        if (buf_wr) begin
            frame_buf[cnt[NUM_WORDS_BITS-1:0]] <= {(cnt == rx_len - 4'd1), RXDATA_IN};
        end
    end

    // Frame parsing FSM, drain pointer and ACK/NAK/error pulse generation
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state       <= RX_IDLE;
            exp_seq     <= 8'd0;
            rx_seq      <= 8'd0;
            rx_len      <= 4'd0;
            cnt         <= 4'd0;
            crc_reg     <= CRC16_INIT;
            committed   <= 1'b0;
            rd_ptr      <= '0;
            ack_vld     <= 1'b0;
            nak_vld     <= 1'b0;
            ack_seq     <= 8'd0;
            crc_err     <= 1'b0;
            framing_err <= 1'b0;
        end else if (!HANDSHAKE_COMPLETE_IN) begin
            state       <= RX_IDLE;
            exp_seq     <= 8'd0;
            cnt         <= 4'd0;
            crc_reg     <= CRC16_INIT;
            committed   <= 1'b0;
            rd_ptr      <= '0;
            ack_vld     <= 1'b0;
            nak_vld     <= 1'b0;
            ack_seq     <= 8'd0;
            crc_err     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            ack_vld     <= 1'b0;
            nak_vld     <= 1'b0;
            ack_seq     <= 8'd0;
            crc_err     <= 1'b0;
            framing_err <= 1'b0;

            if (xfer) begin
                if (frame_buf[rd_ptr][32]) begin
                    committed <= 1'b0;
                    rd_ptr    <= '0;
                end else begin
                    rd_ptr    <= rd_ptr + NUM_WORDS_BITS'(1);
                end
            end

            if (RXVLD_IN) begin
                if ((state != RX_IDLE) && (RXCHARISK_IN != 4'b0000)) begin
                    framing_err <= 1'b1;
                    nak_vld     <= 1'b1;
                    ack_seq     <= exp_seq;
                    state       <= RX_IDLE;
                end

                if (is_hdr) begin
                    if (!len_ok || buf_busy) begin
                        framing_err <= 1'b1;
                        nak_vld     <= 1'b1;
                        ack_seq     <= exp_seq;
                        state       <= RX_IDLE;
                    end else begin
                        state   <= RX_PAYLOAD;
                        rx_seq  <= RXDATA_IN[HDR_SEQ_LSB +: 8];
                        rx_len  <= hdr_len;
                        cnt     <= 4'd0;
                        crc_reg <= crc_next;
                    end
                end else if (RXCHARISK_IN == 4'b0000) begin
                    case (state)
                        RX_PAYLOAD: begin
                            crc_reg <= crc_next;
                            cnt     <= cnt + 4'd1;
                            if (cnt == rx_len - 4'd1) begin
                                state <= RX_CHECK;
                            end
                        end
                        RX_CHECK: begin
                            state <= RX_IDLE;
                            if (RXDATA_IN != {16'h0000, crc_reg}) begin
                                crc_err <= 1'b1;
                                nak_vld <= 1'b1;
                                ack_seq <= exp_seq;
                            end else if (rx_seq != exp_seq) begin
                                nak_vld <= 1'b1;
                                ack_seq <= exp_seq;
                            end else begin
                                ack_vld   <= 1'b1;
                                ack_seq   <= rx_seq;
                                exp_seq   <= exp_seq + 8'd1;
                                committed <= 1'b1;
                                rd_ptr    <= '0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign frm_if.frm_vld  = committed;
    assign frm_if.frm_data = committed ? frame_buf[rd_ptr][31:0] : 32'h0;
    assign frm_if.frm_last = committed ? frame_buf[rd_ptr][32]   : 1'b0;

    assign ACK_VLD_OUT     = ack_vld;
    assign NAK_VLD_OUT     = nak_vld;
    assign ACK_SEQ_OUT     = ack_seq;
    assign CRC_ERR_OUT     = crc_err;
    assign FRAMING_ERR_OUT = framing_err;

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Self-checking bench for the HSS multiplexer frame receiver: a table of
// whole-frame vectors plus hand-written multi-cycle sequences, with expected
// ACK/NAK pulses and payload words queued as a scoreboard.
module tb_spio_hss_multiplexer_frame_rx;
    import spio_hss_multiplexer_frame_rx_pkg::*;

    logic        clk;
    logic        reset;
    logic        handshake;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic        rx_vld;
    logic        ack_vld;
    logic        nak_vld;
    logic [7:0]  ack_seq;
    logic        crc_err;
    logic        framing_err;

    spio_hss_multiplexer_frame_rx_if frm_bus ();

    spio_hss_multiplexer_frame_rx #(
        .NUM_WORDS      (8),
        .NUM_WORDS_BITS (3)
    ) dut (
        .CLK_IN                (clk),
        .RESET_IN              (reset),
        .HANDSHAKE_COMPLETE_IN (handshake),
        .RXDATA_IN             (rx_data),
        .RXCHARISK_IN          (rx_charisk),
        .RXVLD_IN              (rx_vld),
        .frm_if                (frm_bus),
        .ACK_VLD_OUT           (ack_vld),
        .NAK_VLD_OUT           (nak_vld),
        .ACK_SEQ_OUT           (ack_seq),
        .CRC_ERR_OUT           (crc_err),
        .FRAMING_ERR_OUT       (framing_err)
    );

    typedef struct {
        logic [7:0] seq;
        logic [3:0] len;
        logic       hdr_only;
        logic       corrupt;
        logic       exp_ack;
        logic       exp_nak;
        logic       exp_crc_err;
        logic       exp_frm_err;
        logic [7:0] exp_seq;
    } frame_vec_t;

    frame_vec_t  vecs [9];
    logic [11:0] ev_q [$];
    logic [32:0] out_q [$];
    int          checks_passed;
    int          checks_total;
    logic [7:0]  next_seq;
    logic [11:0] mon_got;
    logic [11:0] mon_exp;
    logic [32:0] mon_word;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {w[b*8 +: 8], 8'h00};
            for (int j = 0; j < 8; j++) begin
                r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendWord(input logic [31:0] d, input logic [3:0] k);
        rx_data    = d;
        rx_charisk = k;
        rx_vld     = 1'b1;
        @(posedge clk);
        #1;
        rx_vld     = 1'b0;
        rx_data    = 32'h0;
        rx_charisk = 4'h0;
    endtask

    task automatic pushEvent(input logic ack, input logic nak, input logic crc, input logic frm, input logic [7:0] seq);
        ev_q.push_back({ack, nak, crc, frm, seq});
    endtask

    // Send header, n payload words and the CRC word; queue payload if expected out
    task automatic applyStimulus(input logic [7:0] seq, input logic [3:0] len_field, input int n_words,
                                 input logic corrupt, input logic expect_out);
        logic [31:0] w;
        logic [15:0] c;
        w = {KCH_DATA, seq, 12'h000, len_field};
        c = crcWord(16'hFFFF, w);
        sendWord(w, 4'b1000);
        for (int i = 0; i < n_words; i++) begin
            w = $urandom;
            c = crcWord(c, w);
            if (expect_out) out_q.push_back({(i == n_words - 1), w});
            sendWord(w, 4'b0000);
        end
        if (n_words > 0) sendWord({16'h0000, c ^ {15'h0000, corrupt}}, 4'b0000);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && (ev_q.size() != 0 || out_q.size() != 0); i++) idle(1);
        idle(2);
        checkOutput({name, " events left"}, 33'(ev_q.size()), 33'd0);
        checkOutput({name, " words left"}, 33'(out_q.size()), 33'd0);
        checkOutput({name, " vld idle"}, {32'h0, frm_bus.frm_vld}, 33'd0);
    endtask

    // Scoreboard monitor: pulses and payload transfers sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            mon_got = {ack_vld, nak_vld, crc_err, framing_err, ack_seq};
            if (ack_vld || nak_vld || crc_err || framing_err) begin
                if (ev_q.size() == 0) begin
                    checkOutput("unexpected pulse", {21'h0, mon_got}, 33'd0);
                end else begin
                    mon_exp = ev_q.pop_front();
                    checkOutput("pulse ack/nak/crc/frm/seq", {21'h0, mon_got}, {21'h0, mon_exp});
                end
            end
            if (frm_bus.frm_vld && frm_bus.frm_rdy) begin
                if (out_q.size() == 0) begin
                    checkOutput("unexpected word", {frm_bus.frm_last, frm_bus.frm_data}, 33'd0);
                end else begin
                    mon_word = out_q.pop_front();
                    checkOutput("payload last/data", {frm_bus.frm_last, frm_bus.frm_data}, mon_word);
                end
            end
        end
    end

    initial begin
        checks_passed  = 0;
        checks_total   = 0;
        reset          = 1'b1;
        handshake      = 1'b0;
        rx_data        = 32'h0;
        rx_charisk     = 4'h0;
        rx_vld         = 1'b0;
        frm_bus.frm_rdy = 1'b1;

        //          seq     len   hdr   crpt  ack   nak   crc   frm   exp_seq
        vecs[0] = '{8'd0,   4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{8'd0,   4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{8'd5,   4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[3] = '{8'd254, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd254};
        vecs[4] = '{8'd255, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255};
        vecs[5] = '{8'd0,   4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6] = '{8'd1,   4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[7] = '{8'd1,   4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
        vecs[8] = '{8'd1,   4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

        idle(3);
        checkOutput("reset ack", {32'h0, ack_vld}, 33'd0);
        checkOutput("reset nak", {32'h0, nak_vld}, 33'd0);
        checkOutput("reset seq", {25'h0, ack_seq}, 33'd0);
        checkOutput("reset crc_err", {32'h0, crc_err}, 33'd0);
        checkOutput("reset framing_err", {32'h0, framing_err}, 33'd0);
        checkOutput("reset vld", {32'h0, frm_bus.frm_vld}, 33'd0);
        checkOutput("reset last/data", {frm_bus.frm_last, frm_bus.frm_data}, 33'd0);
        reset     = 1'b0;
        handshake = 1'b1;
        idle(2);

        for (int r = 0; r < 9; r++) begin
            if (r == 3) begin
                for (int s = 1; s <= 253; s++) begin
                    pushEvent(1'b1, 1'b0, 1'b0, 1'b0, 8'(s));
                    applyStimulus(8'(s), 4'd1, 1, 1'b0, 1'b1);
                end
                waitDrain("seq catch-up");
            end
            if (vecs[r].exp_ack || vecs[r].exp_nak)
                pushEvent(vecs[r].exp_ack, vecs[r].exp_nak, vecs[r].exp_crc_err,
                          vecs[r].exp_frm_err, vecs[r].exp_seq);
            applyStimulus(vecs[r].seq, vecs[r].len, vecs[r].hdr_only ? 0 : int'(vecs[r].len),
                          vecs[r].corrupt, vecs[r].exp_ack);
            waitDrain($sformatf("vector %0d", r));
        end
        next_seq = 8'd2;

        // Overrun: committed frame stalled, new header dropped, first frame drains intact
        frm_bus.frm_rdy = 1'b0;
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd2, 2, 1'b0, 1'b1);
        next_seq = next_seq + 8'd1;
        pushEvent(1'b0, 1'b1, 1'b0, 1'b1, next_seq);
        applyStimulus(next_seq, 4'd1, 1, 1'b0, 1'b0);
        idle(2);
        checkOutput("stall vld", {32'h0, frm_bus.frm_vld}, 33'd1);
        checkOutput("stall last/data", {frm_bus.frm_last, frm_bus.frm_data}, out_q[0]);
        frm_bus.frm_rdy = 1'b1;
        waitDrain("overrun");

        // Header arriving with the final drain transfer is accepted
        frm_bus.frm_rdy = 1'b0;
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd1, 1, 1'b0, 1'b1);
        next_seq = next_seq + 8'd1;
        idle(2);
        frm_bus.frm_rdy = 1'b1;
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd1, 1, 1'b0, 1'b1);
        next_seq = next_seq + 8'd1;
        waitDrain("drain-edge header");

        // Aborted frame by K char, long gap, then a good frame
        pushEvent(1'b0, 1'b1, 1'b0, 1'b1, next_seq);
        sendWord({KCH_DATA, next_seq, 12'h000, 4'd4}, 4'b1000);
        sendWord($urandom, 4'b0000);
        sendWord($urandom, 4'b0000);
        sendWord(32'h0000_00BC, 4'b0001);
        idle(5);
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd4, 4, 1'b0, 1'b1);
        next_seq = next_seq + 8'd1;
        waitDrain("k-char abort");

        // Aborted frame by a new header, which is itself taken as a frame
        pushEvent(1'b0, 1'b1, 1'b0, 1'b1, next_seq);
        sendWord({KCH_DATA, next_seq, 12'h000, 4'd4}, 4'b1000);
        sendWord($urandom, 4'b0000);
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd2, 2, 1'b0, 1'b1);
        next_seq = next_seq + 8'd1;
        waitDrain("header abort");

        // Link drop mid-drain flushes output and restarts sequence at 0
        frm_bus.frm_rdy = 1'b0;
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, next_seq);
        applyStimulus(next_seq, 4'd3, 3, 1'b0, 1'b1);
        idle(2);
        frm_bus.frm_rdy = 1'b1;
        idle(1);
        frm_bus.frm_rdy = 1'b0;
        checkOutput("mid-drain vld", {32'h0, frm_bus.frm_vld}, 33'd1);
        handshake = 1'b0;
        idle(1);
        checkOutput("flush vld", {32'h0, frm_bus.frm_vld}, 33'd0);
        out_q.delete();
        applyStimulus(8'd0, 4'd1, 1, 1'b0, 1'b0);
        idle(2);
        checkOutput("link-down pulses", {29'h0, ack_vld, nak_vld, crc_err, framing_err}, 33'd0);
        checkOutput("link-down vld", {32'h0, frm_bus.frm_vld}, 33'd0);
        handshake = 1'b1;
        frm_bus.frm_rdy = 1'b1;
        idle(1);
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd0, 4'd1, 1, 1'b0, 1'b1);
        waitDrain("link drop");

        // Reset mid-frame loses the partial frame and restarts sequence at 0
        sendWord({KCH_DATA, 8'd1, 12'h000, 4'd3}, 4'b1000);
        sendWord($urandom, 4'b0000);
        reset = 1'b1;
        idle(2);
        checkOutput("mid-frame reset vld", {32'h0, frm_bus.frm_vld}, 33'd0);
        reset = 1'b0;
        idle(1);
        pushEvent(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(8'd0, 4'd2, 2, 1'b0, 1'b1);
        waitDrain("reset mid-frame");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
